// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : command/response sequencer for an external registered ALU.
// Optional BCD adjust for ADD/SUB when DECIMAL_MODE_EN is defined. Rev 1.0
// ============================================================================
module alu_sequencer #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_carry,
    input  logic       cmd_decimal,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_error,
    output logic       flag_n,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    input  logic       flag_wr_valid,
    input  logic [3:0] flag_wr_data,
    output logic       alu_enable,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    output logic       alu_carrybit,
    output logic [4:0] alu_op_number,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SHR = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_RTR = 5'd9;
    localparam logic [4:0] OP_RTL = 5'd10;
    localparam logic [4:0] OP_LD  = 5'd12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
`ifdef DECIMAL_MODE_EN
        S_ADJUST = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic [7:0] result_q, result_d;
    logic       error_q, error_d;
    logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
    logic       dec_q, dec_d;
    logic       op_legal;
    logic       cmd_cin;

    assign op_legal = (cmd_op <= OP_RTL) || (cmd_op == OP_LD);
    // SUB carry-in is a borrow, so the stored C is inverted before use.
    assign cmd_cin  = (((cmd_op == OP_ADD) || (cmd_op == OP_RTR) || (cmd_op == OP_RTL))
                       & cmd_use_carry & flags_q[1])
                    | ((cmd_op == OP_SUB) & cmd_use_carry & ~flags_q[1]);

`ifdef DECIMAL_MODE_EN
    logic [4:0] lo_add;
    logic [4:0] lo_sub;
    logic [7:0] bcd_res;
    logic       bcd_c;

    assign lo_add = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, cin_q};
    assign lo_sub = {1'b0, b_q[3:0]} + {4'b0, cin_q};

    always_comb begin
        bcd_res = result_q;
        bcd_c   = flags_q[1];
        if (op_q == OP_ADD) begin
            if (lo_add[4] || (result_q[3:0] > 4'd9)) bcd_res = bcd_res + 8'h06;
            if (flags_q[1] || (result_q > 8'h99)) begin
                bcd_res = bcd_res + 8'h60;
                bcd_c   = 1'b1;
            end
        end else begin
            if ({1'b0, a_q[3:0]} < lo_sub) bcd_res = bcd_res - 8'h06;
            if (!flags_q[1]) bcd_res = bcd_res - 8'h60;
        end
    end
`else
    logic unused_decimal;
    assign unused_decimal = cmd_decimal;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        dec_d      = dec_q;
        result_d   = result_q;
        error_d    = error_q;
        flags_d    = flags_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_error  = 1'b0;
        alu_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    cin_d = cmd_cin;
`ifdef DECIMAL_MODE_EN
                    dec_d = cmd_decimal;
`else
                    dec_d = 1'b0;
`endif
                    if (op_legal) begin
                        state_d = S_ISSUE;
                        error_d = 1'b0;
                    end else begin
                        state_d  = S_DONE;
                        error_d  = 1'b1;
                        result_d = 8'h00;
                    end
                end else if (flag_wr_valid) begin
                    flags_d = flag_wr_data;
                end
            end
            S_ISSUE: begin
                alu_enable = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                result_d   = alu_result;
                flags_d[3] = alu_result[7];
                flags_d[2] = (alu_result == 8'h00);
                case (op_q)
                    OP_ADD: begin
                        flags_d[1] = alu_carry;
                        flags_d[0] = alu_overflow;
                    end
                    OP_SUB: begin
                        flags_d[1] = ~alu_carry;
                        flags_d[0] = alu_overflow;
                    end
                    OP_SHR, OP_SHL, OP_RTR, OP_RTL: flags_d[1] = alu_carry;
                    default: ;
                endcase
                state_d = S_DONE;
`ifdef DECIMAL_MODE_EN
                if (dec_q && ((op_q == OP_ADD) || (op_q == OP_SUB))) state_d = S_ADJUST;
`endif
            end
`ifdef DECIMAL_MODE_EN
            S_ADJUST: begin
                result_d   = bcd_res;
                flags_d[3] = bcd_res[7];
                flags_d[2] = (bcd_res == 8'h00);
                flags_d[1] = bcd_c;
                state_d    = S_DONE;
            end
`endif
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_error = error_q;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 5'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cin_q    <= 1'b0;
            dec_q    <= 1'b0;
            result_q <= 8'h00;
            error_q  <= 1'b0;
            flags_q  <= FLAG_RESET;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            dec_q    <= dec_d;
            result_q <= result_d;
            error_q  <= error_d;
            flags_q  <= flags_d;
        end
    end

    // ALU inputs are held at zero except during the single issue cycle.
    assign alu_operand1  = (state_q == S_ISSUE) ? a_q   : 8'h00;
    assign alu_operand2  = (state_q == S_ISSUE) ? b_q   : 8'h00;
    assign alu_carrybit  = (state_q == S_ISSUE) ? cin_q : 1'b0;
    assign alu_op_number = (state_q == S_ISSUE) ? op_q  : 5'd0;

    assign rsp_result = result_q;
    assign flag_n     = flags_q[3];
    assign flag_z     = flags_q[2];
    assign flag_c     = flags_q[1];
    assign flag_v     = flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed scoreboard bench with a behavioural ALU. Rev 1.0
// ============================================================================
module tb_alu_sequencer;

    localparam logic [3:0] FLAG_RESET = 4'b0100;
`ifdef DECIMAL_MODE_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_op = 5'd0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_use_carry = 1'b0;
    logic       cmd_decimal = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_error;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       flag_wr_valid = 1'b0;
    logic [3:0] flag_wr_data = 4'h0;
    logic       alu_enable;
    logic [7:0] alu_operand1, alu_operand2;
    logic       alu_carrybit;
    logic [4:0] alu_op_number;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;
    logic       alu_overflow = 1'b0;
    logic [3:0] flags;

    always #5 clk = ~clk;

    alu_sequencer #(.FLAG_RESET(FLAG_RESET)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_carry(cmd_use_carry), .cmd_decimal(cmd_decimal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .flag_wr_valid(flag_wr_valid), .flag_wr_data(flag_wr_data),
        .alu_enable(alu_enable), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_carrybit(alu_carrybit), .alu_op_number(alu_op_number),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    assign flags = {flag_n, flag_z, flag_c, flag_v};

    typedef struct {
        logic [7:0] res;
        logic       err;
        logic [3:0] flg;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] tb_flags;
    int         checks = 0;
    int         errors = 0;
    int         en_cnt = 0;

    // Returns {V, C(or borrow), result}.
    function automatic logic [9:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            5'd1: begin
                s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a + 8'd1;
            5'd6:  r = a - 8'd1;
            5'd7:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            5'd8:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            5'd9:  begin r = {cin, a[7:1]};  c = a[0]; end
            5'd10: begin r = {a[6:0], cin};  c = a[7]; end
            5'd12: r = b;
            default: r = 8'h00;
        endcase
        return {v, c, r};
    endfunction

    always @(posedge clk) begin
        if (alu_enable) begin
            {alu_overflow, alu_carry, alu_result} <= alu_f(alu_op_number, alu_operand1,
                                                           alu_operand2, alu_carrybit);
            en_cnt <= en_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic uc, input logic dec);
        exp_t       e;
        logic       cin;
        logic [9:0] o;
        logic [4:0] lo, hi;
        if (!((op <= 5'd10) || (op == 5'd12))) begin
            e.res = 8'h00; e.err = 1'b1; e.lat = 0;
        end else begin
            cin = (((op == 5'd0) || (op == 5'd9) || (op == 5'd10)) && uc && tb_flags[1])
               || ((op == 5'd1) && uc && !tb_flags[1]);
            o = alu_f(op, a, b, cin);
            e.res = o[7:0]; e.err = 1'b0; e.lat = 2;
            tb_flags[3] = o[7];
            tb_flags[2] = (o[7:0] == 8'h00);
            case (op)
                5'd0: begin tb_flags[1] = o[8];  tb_flags[0] = o[9]; end
                5'd1: begin tb_flags[1] = ~o[8]; tb_flags[0] = o[9]; end
                5'd7, 5'd8, 5'd9, 5'd10: tb_flags[1] = o[8];
                default: ;
            endcase
            if (DEC_EN && dec && (op == 5'd0)) begin
                lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
                if (lo > 5'd9) lo = lo + 5'd6;
                hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo[4]};
                if (hi > 5'd9) hi = hi + 5'd6;
                e.res = {hi[3:0], lo[3:0]};
                tb_flags[3] = e.res[7];
                tb_flags[2] = (e.res == 8'h00);
                tb_flags[1] = hi[4];
                e.lat = 3;
            end
        end
        e.flg = tb_flags;
        sb.push_back(e);
    endtask

    task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic uc, input logic dec);
        int n;
        push_exp(op, a, b, uc, dec);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_carry = uc; cmd_decimal = dec;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_timeout", (n >= 50), 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic recv(input bit check_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("rsp_timeout", (n >= 50), 1'b0);
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (check_lat) chk("latency", n, e.lat);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_error", rsp_error, e.err);
        chk("flags", flags, e.flg);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
    endtask

    task automatic flag_write(input logic [3:0] d);
        flag_wr_valid = 1'b1; flag_wr_data = d;
        @(posedge clk); #1;
        flag_wr_valid = 1'b0;
        tb_flags = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] t_op [12];
        logic [7:0] t_a  [12];
        logic [7:0] t_b  [12];
        logic       t_uc [12];
        int         en0;
        logic       stable, seen;

        t_op = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12, 5'd0, 5'd1};
        t_a  = '{8'hF0, 8'h0F, 8'hAA, 8'hFF, 8'h00, 8'h03, 8'h81, 8'h02, 8'h80, 8'h00, 8'hFF, 8'h50};
        t_b  = '{8'h3C, 8'h80, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9C, 8'h01, 8'h70};
        t_uc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        tb_flags = FLAG_RESET;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 8'h00);
        chk("rst_rsp_error", rsp_error, 1'b0);
        chk("rst_alu_enable", alu_enable, 1'b0);
        chk("rst_alu_bus", {alu_operand1, alu_operand2, alu_carrybit, alu_op_number}, 32'h0);
        chk("rst_flags", flags, FLAG_RESET);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed overflow on ADD.
        send(5'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        recv(1'b1);

        flag_write(4'b0010);
        chk("flag_wr_c_only", flags, 4'b0010);

        // Borrow with C=1 as "no borrow".
        send(5'd1, 8'h00, 8'h01, 1'b1, 1'b0);
        recv(1'b1);

        for (int i = 0; i < 12; i++) begin
            send(t_op[i], t_a[i], t_b[i], t_uc[i], 1'b0);
            recv(1'b1);
        end

        // Illegal op bypasses the ALU.
        en0 = en_cnt;
        send(5'd13, 8'h12, 8'h34, 1'b0, 1'b0);
        recv(1'b1);
        chk("illegal_no_alu", en_cnt, en0);

        // Command acceptance beats a same-cycle flag write.
        push_exp(5'd2, 8'h0F, 8'h0F, 1'b0, 1'b0);
        cmd_op = 5'd2; cmd_a = 8'h0F; cmd_b = 8'h0F; cmd_use_carry = 1'b0;
        cmd_valid = 1'b1; flag_wr_valid = 1'b1; flag_wr_data = 4'b1011;
        @(posedge clk); #1;
        cmd_valid = 1'b0; flag_wr_valid = 1'b0;
        recv(1'b1);

        // Flag writes outside IDLE are ignored.
        send(5'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        flag_wr_valid = 1'b1; flag_wr_data = 4'b1111;
        repeat (2) begin @(posedge clk); #1; end
        flag_wr_valid = 1'b0;
        recv(1'b0);

        // Response backpressure with a competing command.
        send(5'd0, 8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        push_exp(5'd3, 8'h0F, 8'hF0, 1'b0, 1'b0);
        cmd_op = 5'd3; cmd_a = 8'h0F; cmd_b = 8'hF0; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
        en0 = en_cnt;
        stable = 1'b1;
        repeat (5) begin
            if (!(rsp_valid && (rsp_result == 8'h30) && !cmd_ready)) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_no_accept", en_cnt, en0);
        recv(1'b0);
        chk("bp_idle_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        recv(1'b1);

        // Reset in WAIT aborts the operation.
        send(5'd0, 8'h01, 8'h02, 1'b0, 1'b0);
        sb.delete(sb.size() - 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("wrst_cmd_ready", cmd_ready, 1'b1);
        chk("wrst_rsp_valid", rsp_valid, 1'b0);
        chk("wrst_flags", flags, FLAG_RESET);
        rst_n = 1'b1;
        tb_flags = FLAG_RESET;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
        chk("wrst_no_rsp", seen, 1'b0);

        send(5'd4, 8'h5A, 8'h0F, 1'b0, 1'b0);
        recv(1'b1);

`ifdef DECIMAL_MODE_EN
        send(5'd0, 8'h19, 8'h28, 1'b0, 1'b1);
        recv(1'b1);
        send(5'd0, 8'h99, 8'h01, 1'b0, 1'b1);
        recv(1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
